// File: rtl/bcd_sequencer_if.sv
// bcd_sequencer_if: handshake between the BCD sequencer and an external divide-by-10 unit.
//   div_start      one-cycle request pulse; qualifies div_value
//   div_value      14-bit dividend
//   div_quotient   10-bit quotient returned by the divider
//   div_remainder  4-bit remainder returned by the divider, 0..9
//   div_ready      divider result valid
// master: the sequencer side. slave: the divider side.
interface bcd_sequencer_if;
  logic        div_start;
  logic [13:0] div_value;
  logic [9:0]  div_quotient;
  logic [3:0]  div_remainder;
  logic        div_ready;

  modport master (
    output div_start,
    output div_value,
    input  div_quotient,
    input  div_remainder,
    input  div_ready
  );

  modport slave (
    input  div_start,
    input  div_value,
    output div_quotient,
    output div_remainder,
    output div_ready
  );
endinterface

// File: rtl/bcd_sequencer.sv
// bcd_sequencer: converts a 14-bit binary value (0..9999) to four BCD digits by issuing four
// successive requests to an external divide-by-10 unit and collecting the remainders.
// Out-of-range values (>9999) finish immediately with 9999 and overflow set.
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     conversion request, only honoured in IDLE
//   value     14-bit operand
//   busy      high from the cycle after an accepted start through the DONE cycle
//   done      one-cycle completion pulse; bcd/blank/overflow are valid in that cycle
//   bcd       four BCD digits, [15:12] thousands .. [3:0] units
//   blank     leading-zero mask, bit i set means digit i is blanked
//   overflow  last accepted value was >9999
//   div       divider handshake (master side)
module bcd_sequencer (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [13:0]            value,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            bcd,
  output logic [3:0]             blank,
  output logic                   overflow,
  bcd_sequencer_if.master        div
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StGuard = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [13:0] MaxValue = 14'd9999;

  logic [2:0]       state_q, state_d;
  logic [13:0]      operand_q, operand_d;
  logic [1:0]       index_q, index_d;
  logic [3:0][3:0]  digits_q, digits_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       blank_q, blank_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    index_d    = index_q;
    digits_d   = digits_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (value <= MaxValue) begin
            operand_d = value;
            index_d   = 2'd0;
            state_d   = StIssue;
          end else begin
            // Saturate: result registers load on entry to DONE so they are valid with done.
            bcd_d      = 16'h9999;
            blank_d    = 4'b0000;
            overflow_d = 1'b1;
            state_d    = StDone;
          end
        end
      end
      StIssue: state_d = StGuard;
      // One dead cycle so a ready left over from the previous request is never taken.
      StGuard: state_d = StWait;
      StWait: begin
        if (div.div_ready) begin
          digits_d[index_q] = div.div_remainder;
          operand_d         = {4'b0000, div.div_quotient};
          if (index_q == 2'd3) begin
            // Thousands digit arrives now; build the result straight from it.
            bcd_d      = {div.div_remainder, digits_q[2], digits_q[1], digits_q[0]};
            blank_d[3] = (div.div_remainder == 4'd0);
            blank_d[2] = (div.div_remainder == 4'd0) && (digits_q[2] == 4'd0);
            blank_d[1] = (div.div_remainder == 4'd0) && (digits_q[2] == 4'd0) &&
                         (digits_q[1] == 4'd0);
            blank_d[0] = 1'b0;
            overflow_d = 1'b0;
            state_d    = StDone;
          end else begin
            index_d = index_q + 2'd1;
            state_d = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      operand_q  <= '0;
      index_q    <= '0;
      digits_q   <= '0;
      bcd_q      <= '0;
      blank_q    <= 4'b1110;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      index_q    <= index_d;
      digits_q   <= digits_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign bcd           = bcd_q;
  assign blank         = blank_q;
  assign overflow      = overflow_q;
  assign div.div_start = (state_q == StIssue);
  assign div.div_value = operand_q;

endmodule

// File: tb/tb_bcd_sequencer.sv
// Scoreboard bench for bcd_sequencer with a behavioural divide-by-10 unit of configurable
// latency k. Expected divider operands and results are queued by the stimulus; monitors pop
// and compare whenever the DUT pulses div_start or done.
module tb_bcd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] value;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        overflow;

  bcd_sequencer_if div_bus ();

  bcd_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .blank    (blank),
    .overflow (overflow),
    .div      (div_bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: age counts cycles since the div_start cycle (age=1 in the following cycle).
  // ready holds high once the result is available until the next request is seen.
  // In stale mode a bogus ready (with garbage data) is also shown at age 1.
  int          k     = 2;
  bit          stale = 1'b0;
  int          age   = 0;
  logic [13:0] div_op = '0;

  always @(posedge clk) begin
    if (rst) begin
      age <= 0;
    end else if (div_bus.div_start) begin
      div_op <= div_bus.div_value;
      age    <= 1;
    end else if (age != 0 && age < 1000) begin
      age <= age + 1;
    end
  end

  always_comb begin
    div_bus.div_ready     = (age != 0) && ((age >= k) || (stale && age == 1));
    div_bus.div_quotient  = 10'd0;
    div_bus.div_remainder = 4'd9;
    if (age >= k) begin
      div_bus.div_quotient  = 10'(div_op / 14'd10);
      div_bus.div_remainder = 4'(div_op % 14'd10);
    end
  end

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
    int          due;
  } res_t;

  res_t        res_q[$];
  logic [13:0] dv_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors
  logic [20:0] prev_out = '0;
  res_t        mr;
  logic [13:0] mdv;

  always @(negedge clk) begin
    if (!rst) begin
      if (div_bus.div_start) begin
        if (dv_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL div_start: unexpected pulse with div_value %0d at cycle %0d",
                   div_bus.div_value, cyc);
        end else begin
          mdv = dv_q.pop_front();
          chk("div_value", 32'(div_bus.div_value), 32'(mdv));
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done: unexpected pulse at cycle %0d, bcd %0h", cyc, bcd);
        end else begin
          mr = res_q.pop_front();
          chk("bcd", 32'(bcd), 32'(mr.bcd));
          chk("blank", 32'(blank), 32'(mr.blank));
          chk("overflow", 32'(overflow), 32'(mr.ovf));
          chk("done cycle", 32'(cyc), 32'(mr.due));
        end
      end
      // Result registers may only move in the DONE cycle.
      if (busy && !done) chk("result hold", 32'({bcd, blank, overflow}), 32'(prev_out));
    end
    prev_out = {bcd, blank, overflow};
  end

  task automatic drain();
    int i;
    for (i = 0; i < 300 && res_q.size() != 0; i++) @(posedge clk);
    if (res_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: no done within 300 cycles, got none, expected one");
      res_q.delete();
    end
    chk("div_start count left", 32'(dv_q.size()), 32'd0);
    dv_q.delete();
    @(posedge clk);
  endtask

  // One conversion; poke>0 re-pulses start (value=1) that many cycles into the conversion.
  task automatic conv(input logic [13:0] v, input logic [15:0] eb, input logic [3:0] ebl,
                      input logic eo, input int kk, input bit st, input int poke);
    res_t r;
    int   m;
    k     = kk;
    stale = st;
    // A ready landing in GUARD (k=1) is only taken in the first WAIT cycle.
    m = (kk < 2) ? 2 : kk;
    @(posedge clk);
    #1;
    start = 1'b1;
    value = v;
    r.bcd   = eb;
    r.blank = ebl;
    r.ovf   = eo;
    if (v <= 14'd9999) begin
      dv_q.push_back(v);
      dv_q.push_back(v / 14'd10);
      dv_q.push_back(v / 14'd100);
      dv_q.push_back(v / 14'd1000);
      r.due = cyc + 4 * (m + 1) + 1;
    end else begin
      r.due = cyc + 1;
    end
    res_q.push_back(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1;
      start = 1'b1;
      value = 14'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    drain();
  endtask

  initial begin
    res_t r;
    rst   = 1'b1;
    start = 1'b1;
    value = 14'd5;
    // Reset wins over a simultaneous start.
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div_start", 32'(div_bus.div_start), 32'd0);
    chk("reset bcd", 32'(bcd), 32'h0000);
    chk("reset blank", 32'(blank), 32'b1110);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset div_value", 32'(div_bus.div_value), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle after reset", 32'(busy), 32'd0);

    conv(14'd4934, 16'h4934, 4'b0000, 1'b0, 1, 1'b0, 0);
    conv(14'd4934, 16'h4934, 4'b0000, 1'b0, 10, 1'b0, 0);
    conv(14'd0,    16'h0000, 4'b1110, 1'b0, 2, 1'b0, 0);
    conv(14'd7,    16'h0007, 4'b1110, 1'b0, 10, 1'b1, 0);
    conv(14'd120,  16'h0120, 4'b1000, 1'b0, 10, 1'b1, 0);
    conv(14'd4934, 16'h4934, 4'b0000, 1'b0, 2, 1'b0, 4);
    conv(14'd10000, 16'h9999, 4'b0000, 1'b1, 2, 1'b0, 0);
    conv(14'd9999, 16'h9999, 4'b0000, 1'b0, 3, 1'b0, 0);
    conv(14'd16383, 16'h9999, 4'b0000, 1'b1, 2, 1'b0, 0);

    // Abort during WAIT of digit 2 (k=10): ISSUE of digit 2 is 23 cycles after start.
    k     = 10;
    stale = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    value = 14'd4934;
    dv_q.push_back(14'd4934);
    dv_q.push_back(14'd493);
    dv_q.push_back(14'd49);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    chk("busy before abort", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort div_start", 32'(div_bus.div_start), 32'd0);
    chk("abort bcd", 32'(bcd), 32'h0000);
    chk("abort blank", 32'(blank), 32'b1110);
    chk("abort overflow", 32'(overflow), 32'd0);
    chk("abort div_start count", 32'(dv_q.size()), 32'd0);
    dv_q.delete();
    // Start in the very first cycle after reset.
    start = 1'b1;
    value = 14'd56;
    dv_q.push_back(14'd56);
    dv_q.push_back(14'd5);
    dv_q.push_back(14'd0);
    dv_q.push_back(14'd0);
    r.bcd   = 16'h0056;
    r.blank = 4'b1100;
    r.ovf   = 1'b0;
    r.due   = cyc + 4 * (10 + 1) + 1;
    res_q.push_back(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/bcd_sequencer.md
BCD_SEQUENCER -- requirements
Module: bcd_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  conversion request, sampled in IDLE only.
REQ-005 value  in  14  unsigned binary operand, valid range 0..9999.
REQ-006 busy  out  1  high from the cycle after an accepted start through the DONE cycle.
REQ-007 done  out  1  one-cycle pulse when a conversion completes.
REQ-008 bcd  out  16  four BCD digits: [15:12]=thousands down to [3:0]=units.
REQ-009 blank  out  4  leading-zero mask; bit i=1 means digit i is to be blanked.
REQ-010 overflow  out  1  set when the last accepted value was >9999.
REQ-011 div_start  out  1  one-cycle start pulse to the divide-by-10 unit.
REQ-012 div_value  out  14  operand to the divider; valid during the div_start cycle.
REQ-013 div_quotient  in  10  divider quotient.
REQ-014 div_remainder  in  4  divider remainder, 0..9.
REQ-015 div_ready  in  1  divider result valid.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, GUARD, WAIT and DONE.
REQ-017 IDLE with start=1 and value<=9999: latch value into the 14-bit operand register, clear the digit index to 0, and go to ISSUE.
REQ-018 IDLE with start=1 and value>9999: go directly to DONE with no div_start; at DONE load bcd=16'h9999, blank=4'b0000 and overflow=1.
REQ-019 ISSUE: div_start=1 for exactly this cycle, div_value=operand; next state GUARD.
REQ-020 GUARD: div_ready is ignored for exactly one cycle, which masks a stale ready from the previous operation; next state WAIT.
REQ-021 WAIT: while div_ready=0, hold. When div_ready=1:
  - store div_remainder into shadow digit[index];
  - load operand with div_quotient zero-extended to 14 bits;
  - if index=3, go to DONE; otherwise increment index and go to ISSUE.
REQ-022 DONE: done=1 for one cycle. On a normal path, copy the shadow digits to bcd, compute blank, and clear overflow. Next state IDLE.
REQ-023 bcd, blank and overflow SHALL change only in the DONE cycle and hold their values otherwise, including during a conversion.
REQ-024 blank[i] SHALL be 1 when digit i and all higher digits are zero, for i=1..3; blank[0] SHALL always be 0.
REQ-025 start asserted in any state other than IDLE SHALL be ignored, with no queuing.
REQ-026 Exactly four div_start pulses SHALL occur per in-range conversion, with operands value, value/10, value/100 and value/1000.
REQ-027 Latency for an in-range conversion, where the divider raises ready k>=1 cycles after div_start: done SHALL rise (4*(k+1))+1 cycles after the cycle in which start is sampled.
REQ-028 Latency for an out-of-range value: done SHALL rise 1 cycle after start is sampled.
REQ-029 div_value SHALL be driven with the operand register at all times; only div_start qualifies it.

Reset
REQ-030 rst=1 SHALL force state IDLE and set busy=0, done=0, div_start=0, bcd=16'h0000, blank=4'b1110, overflow=0, index=0 and operand=0.
REQ-031 rst asserted mid-conversion SHALL abort it with no done pulse, and SHALL take priority over start in the same cycle.
REQ-032 After rst deasserts, a start SHALL be accepted in the very next cycle.

Verification
REQ-033 The bench SHALL model the divider behaviourally with a configurable k, covering k=1 and k=10, plus a stale div_ready=1 held across the GUARD cycle.
REQ-034 value=4934, start pulse -> div_value sequence 4934, 493, 49, 4; then bcd=16'h4934, blank=0000, overflow=0, done pulse at cycle 4(k+1)+1.
REQ-035 value=0 -> bcd=16'h0000, blank=1110. value=7 -> bcd=16'h0007, blank=1110. value=120 -> bcd=16'h0120, blank=1000.
REQ-036 value=10000 -> no div_start; done one cycle later; bcd=16'h9999, overflow=1. A following value=9999 -> bcd=16'h9999, overflow=0.
REQ-037 start re-pulsed with value=1 during the conversion of 4934 -> ignored; the result is still 16'h4934 and there are only four div_start pulses.
REQ-038 rst during WAIT of digit 2 -> no done pulse; outputs return to their reset values; a new conversion of 56 then yields bcd=16'h0056, blank=1100.
